// File: rtl/commit_trace_unit_if.sv
// Retire-stage sample bus in, commit-trace record stream out, plus status flags.
interface commit_trace_unit_if #(
  parameter int INUM_W = 24
);
  logic              commit_valid;
  logic [15:0]       pc;
  logic              reg_write;
  logic [3:0]        write_reg;
  logic [15:0]       write_data;
  logic              mem_read;
  logic              mem_write;
  logic [15:0]       mem_addr;
  logic [15:0]       mem_data;
  logic              halt;
  logic              out_valid;
  logic              out_ready;
  logic [2:0]        out_kind;
  logic [INUM_W-1:0] out_inum;
  logic [15:0]       out_pc;
  logic [3:0]        out_reg;
  logic [15:0]       out_value;
  logic [15:0]       out_addr;
  logic              stall_req;
  logic              overflow;
  logic              done;

  modport slave (
    input  commit_valid, pc, reg_write, write_reg, write_data, mem_read,
           mem_write, mem_addr, mem_data, halt, out_ready,
    output out_valid, out_kind, out_inum, out_pc, out_reg, out_value,
           out_addr, stall_req, overflow, done
  );

  modport master (
    output commit_valid, pc, reg_write, write_reg, write_data, mem_read,
           mem_write, mem_addr, mem_data, halt, out_ready,
    input  out_valid, out_kind, out_inum, out_pc, out_reg, out_value,
           out_addr, stall_req, overflow, done
  );
endinterface

// File: rtl/commit_trace_unit.sv
// Classifies each retirement, tags it with an instruction number and streams it out via a FIFO.
// Latency 1 cycle commit-to-out_valid when empty; HALT/TIMEOUT park in a side register when full.
module commit_trace_unit #(
  parameter int DEPTH      = 8,
  parameter int INUM_W     = 24,
  parameter int MAX_CYCLES = 100000
) (
  input logic          clk,
  input logic          rst_n,
  commit_trace_unit_if.slave tif
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(MAX_CYCLES + 1);
  localparam logic [2:0] K_NOP = 3'd0, K_REG = 3'd1, K_LD = 3'd2,
                         K_ST = 3'd3, K_HALT = 3'd4, K_TIMEOUT = 3'd5;

  typedef struct packed {
    logic [2:0]        kind;
    logic [INUM_W-1:0] inum;
    logic [15:0]       pc;
    logic [3:0]        rgn;
    logic [15:0]       value;
    logic [15:0]       addr;
  } rec_t;

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_DONE} state_t;

  state_t            state_q, state_d;
  rec_t              mem_q [DEPTH];
  rec_t              mem_d [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic [INUM_W-1:0] inum_q, inum_d;
  logic [CW-1:0]     cyc_q, cyc_d;
  rec_t              park_q, park_d;
  logic              park_vld_q, park_vld_d;
  logic              overflow_q, overflow_d;
  logic              done_q, done_d;

  rec_t new_rec, push_rec, head;
  logic new_vld, new_term, timeout, full, pop, push, out_vld;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign out_vld = (count_q != '0) && (state_q != S_DONE);
  assign pop     = out_vld && tif.out_ready;
  assign head    = out_vld ? mem_q[rd_ptr_q] : '0;

  assign tif.out_valid = out_vld;
  assign tif.out_kind  = head.kind;
  assign tif.out_inum  = head.inum;
  assign tif.out_pc    = head.pc;
  assign tif.out_reg   = head.rgn;
  assign tif.out_value = head.value;
  assign tif.out_addr  = head.addr;
  assign tif.stall_req = (count_q >= (AW+1)'(DEPTH - 1));
  assign tif.overflow  = overflow_q;
  assign tif.done      = done_q;

  // A timeout preempts any commit sampled in the same cycle.
  always_comb begin
    new_rec      = '0;
    timeout      = (state_q == S_RUN) && (cyc_q == CW'(MAX_CYCLES));
    new_vld      = (state_q == S_RUN) && (timeout || tif.commit_valid);
    new_rec.inum = inum_q;
    new_rec.pc   = tif.pc;
    if (timeout) begin
      new_rec.kind = K_TIMEOUT;
    end else if (tif.reg_write && tif.mem_read) begin
      new_rec.kind  = K_LD;
      new_rec.rgn   = tif.write_reg;
      new_rec.value = tif.write_data;
      new_rec.addr  = tif.mem_addr;
    end else if (tif.reg_write) begin
      new_rec.kind  = K_REG;
      new_rec.rgn   = tif.write_reg;
      new_rec.value = tif.write_data;
    end else if (tif.halt) begin
      new_rec.kind = K_HALT;
    end else if (tif.mem_write) begin
      new_rec.kind  = K_ST;
      new_rec.value = tif.mem_data;
      new_rec.addr  = tif.mem_addr;
    end else begin
      new_rec.kind = K_NOP;
    end
    new_term = (new_rec.kind == K_HALT) || (new_rec.kind == K_TIMEOUT);
  end

  always_comb begin
    state_d    = state_q;
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    inum_d     = inum_q;
    cyc_d      = cyc_q;
    park_d     = park_q;
    park_vld_d = park_vld_q;
    overflow_d = overflow_q;
    push       = 1'b0;
    push_rec   = park_q;

    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);

    // The side register is only occupied in DRAIN, where no new records arise.
    if (park_vld_q) begin
      if (!full || pop) begin
        push       = 1'b1;
        park_vld_d = 1'b0;
      end
    end else if (new_vld) begin
      push_rec = new_rec;
      if (!full || pop) begin
        push = 1'b1;
      end else if (new_term) begin
        park_d     = new_rec;
        park_vld_d = 1'b1;
      end else begin
        overflow_d = 1'b1;
      end
    end

    if (push) begin
      mem_d[wr_ptr_q] = push_rec;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);

    if (new_vld) inum_d = inum_q + INUM_W'(1);
    if (state_q == S_RUN) cyc_d = cyc_q + CW'(1);

    case (state_q)
      S_RUN:   if (new_vld && new_term) state_d = S_DRAIN;
      S_DRAIN: if (count_d == '0 && !park_vld_d) state_d = S_DONE;
      default: state_d = S_DONE;
    endcase
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_RUN;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      inum_q     <= '0;
      cyc_q      <= '0;
      park_q     <= '0;
      park_vld_q <= 1'b0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      inum_q     <= inum_d;
      cyc_q      <= cyc_d;
      park_q     <= park_d;
      park_vld_q <= park_vld_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
    end
  end
endmodule

// File: tb/tb_commit_trace_unit.sv
// Directed bench: main instance for stream/overflow/halt/reset, a second with a short cycle limit.
module tb_commit_trace_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vecs = 0;
  int   errs = 0;

  always #5 clk = ~clk;

  commit_trace_unit_if #(.INUM_W(24)) u_if ();
  commit_trace_unit_if #(.INUM_W(24)) t_if ();

  commit_trace_unit #(.DEPTH(8), .INUM_W(24), .MAX_CYCLES(100000)) u_dut (
    .clk(clk), .rst_n(rst_n), .tif(u_if)
  );
  commit_trace_unit #(.DEPTH(8), .INUM_W(24), .MAX_CYCLES(20)) t_dut (
    .clk(clk), .rst_n(rst_n), .tif(t_if)
  );

  // {valid, kind, inum, pc, reg, value, addr}
  logic [79:0] obs, tobs;
  assign obs  = {u_if.out_valid, u_if.out_kind, u_if.out_inum, u_if.out_pc,
                 u_if.out_reg, u_if.out_value, u_if.out_addr};
  assign tobs = {t_if.out_valid, t_if.out_kind, t_if.out_inum, t_if.out_pc,
                 t_if.out_reg, t_if.out_value, t_if.out_addr};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic cv, input logic [15:0] p, input logic rw,
                       input logic [3:0] wr, input logic [15:0] wd, input logic mr,
                       input logic mw, input logic [15:0] ma, input logic [15:0] md,
                       input logic h);
    u_if.commit_valid = cv; u_if.pc = p; u_if.reg_write = rw; u_if.write_reg = wr;
    u_if.write_data = wd; u_if.mem_read = mr; u_if.mem_write = mw;
    u_if.mem_addr = ma; u_if.mem_data = md; u_if.halt = h;
  endtask

  task automatic idle();
    drive(1'b0, 16'h0, 1'b0, 4'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
  endtask

  task automatic do_reset();
    idle();
    u_if.out_ready = 1'b0;
    t_if.out_ready = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    vecs++;
    if (obs !== 80'h0) begin
      errs++; $display("FAIL reset_record got %h exp %h", obs, 80'h0);
    end
    vecs++;
    if ({u_if.overflow, u_if.done, u_if.stall_req} !== 3'b000) begin
      errs++; $display("FAIL reset_flags got %b exp 000", {u_if.overflow, u_if.done, u_if.stall_req});
    end
  endtask

  task automatic test_basic();
    do_reset();
    u_if.out_ready = 1'b1;
    drive(1'b1, 16'h0000, 1'b1, 4'd3, 16'h1234, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    tick();
    vecs++;
    if (obs !== {1'b1, 3'd1, 24'd0, 16'h0000, 4'd3, 16'h1234, 16'h0000}) begin
      errs++; $display("FAIL basic_reg got %h", obs);
    end
    drive(1'b1, 16'h0002, 1'b0, 4'd0, 16'h0, 1'b0, 1'b1, 16'h0010, 16'hBEEF, 1'b0);
    tick();
    vecs++;
    if (obs !== {1'b1, 3'd3, 24'd1, 16'h0002, 4'd0, 16'hBEEF, 16'h0010}) begin
      errs++; $display("FAIL basic_st got %h", obs);
    end
    drive(1'b1, 16'h0004, 1'b0, 4'd0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1);
    tick();
    vecs++;
    if (obs !== {1'b1, 3'd4, 24'd2, 16'h0004, 4'd0, 16'h0, 16'h0} || u_if.done !== 1'b0) begin
      errs++; $display("FAIL basic_halt got %h done %b", obs, u_if.done);
    end
    idle();
    tick();
    vecs++;
    if (u_if.done !== 1'b1 || u_if.out_valid !== 1'b0) begin
      errs++; $display("FAIL basic_done got done %b valid %b exp 1 0", u_if.done, u_if.out_valid);
    end
  endtask

  task automatic test_classify();
    do_reset();
    u_if.out_ready = 1'b1;
    drive(1'b1, 16'h0006, 1'b1, 4'd5, 16'h00AA, 1'b1, 1'b0, 16'h0020, 16'h7777, 1'b0);
    tick();
    vecs++;
    if (obs !== {1'b1, 3'd2, 24'd0, 16'h0006, 4'd5, 16'h00AA, 16'h0020}) begin
      errs++; $display("FAIL classify_ld got %h", obs);
    end
    drive(1'b1, 16'h0008, 1'b0, 4'd7, 16'h5555, 1'b0, 1'b0, 16'h1111, 16'h2222, 1'b0);
    tick();
    vecs++;
    if (obs !== {1'b1, 3'd0, 24'd1, 16'h0008, 4'd0, 16'h0, 16'h0}) begin
      errs++; $display("FAIL classify_nop got %h", obs);
    end
    drive(1'b1, 16'h000A, 1'b0, 4'd2, 16'h3333, 1'b1, 1'b0, 16'h0044, 16'h9999, 1'b0);
    tick();
    vecs++;
    if (obs !== {1'b1, 3'd0, 24'd2, 16'h000A, 4'd0, 16'h0, 16'h0}) begin
      errs++; $display("FAIL classify_rdonly got %h", obs);
    end
    drive(1'b1, 16'h000C, 1'b1, 4'd9, 16'hCAFE, 1'b0, 1'b1, 16'h0050, 16'h1357, 1'b1);
    tick();
    vecs++;
    if (obs !== {1'b1, 3'd1, 24'd3, 16'h000C, 4'd9, 16'hCAFE, 16'h0}) begin
      errs++; $display("FAIL classify_reg_prio got %h", obs);
    end
    drive(1'b1, 16'h000E, 1'b0, 4'd1, 16'h4444, 1'b0, 1'b1, 16'h0060, 16'h8888, 1'b1);
    tick();
    vecs++;
    if (obs !== {1'b1, 3'd4, 24'd4, 16'h000E, 4'd0, 16'h0, 16'h0}) begin
      errs++; $display("FAIL classify_halt_prio got %h", obs);
    end
    idle();
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 16'(2 * i), 1'b1, 4'(i), 16'(16'h0100 + i), 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
      tick();
      vecs++;
      if (u_if.stall_req !== (i >= 6) || u_if.overflow !== (i >= 8)) begin
        errs++; $display("FAIL ovf_fill_%0d got stall %b ovf %b exp %b %b", i,
                         u_if.stall_req, u_if.overflow, (i >= 6), (i >= 8));
      end
    end
    idle();
    u_if.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      vecs++;
      if (obs !== {1'b1, 3'd1, 24'(i), 16'(2 * i), 4'(i), 16'(16'h0100 + i), 16'h0}) begin
        errs++; $display("FAIL ovf_drain_%0d got %h", i, obs);
      end
      tick();
    end
    vecs++;
    if (u_if.out_valid !== 1'b0 || u_if.overflow !== 1'b1) begin
      errs++; $display("FAIL ovf_empty got valid %b ovf %b exp 0 1", u_if.out_valid, u_if.overflow);
    end
    drive(1'b1, 16'h0100, 1'b1, 4'd4, 16'h0ABC, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    tick();
    vecs++;
    if (obs !== {1'b1, 3'd1, 24'd10, 16'h0100, 4'd4, 16'h0ABC, 16'h0}) begin
      errs++; $display("FAIL ovf_next_inum got %h", obs);
    end
    idle();
  endtask

  task automatic test_halt_full();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 16'(2 * i), 1'b1, 4'(i), 16'(16'h0100 + i), 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
      tick();
    end
    drive(1'b1, 16'h0040, 1'b0, 4'd0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1);
    tick();
    vecs++;
    if (u_if.overflow !== 1'b0 || obs !== {1'b1, 3'd1, 24'd0, 16'h0000, 4'd0, 16'h0100, 16'h0}) begin
      errs++; $display("FAIL halt_park got ovf %b head %h", u_if.overflow, obs);
    end
    drive(1'b1, 16'h0042, 1'b1, 4'd6, 16'h6666, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    tick();
    idle();
    u_if.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      vecs++;
      if (obs !== {1'b1, 3'd1, 24'(i), 16'(2 * i), 4'(i), 16'(16'h0100 + i), 16'h0}) begin
        errs++; $display("FAIL halt_drain_%0d got %h", i, obs);
      end
      tick();
    end
    vecs++;
    if (obs !== {1'b1, 3'd4, 24'd8, 16'h0040, 4'd0, 16'h0, 16'h0} || u_if.done !== 1'b0) begin
      errs++; $display("FAIL halt_emerge got %h done %b", obs, u_if.done);
    end
    tick();
    vecs++;
    if (u_if.done !== 1'b1 || u_if.out_valid !== 1'b0 || u_if.overflow !== 1'b0) begin
      errs++; $display("FAIL halt_done got done %b valid %b ovf %b exp 1 0 0",
                       u_if.done, u_if.out_valid, u_if.overflow);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    t_if.out_ready = 1'b1;
    t_if.reg_write = 1'b0; t_if.write_reg = 4'd0; t_if.write_data = 16'h0;
    t_if.mem_read = 1'b0; t_if.mem_write = 1'b0; t_if.mem_addr = 16'h0;
    t_if.mem_data = 16'h0; t_if.halt = 1'b0;
    t_if.commit_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      t_if.pc = 16'(2 * k);
      tick();
      vecs++;
      if (tobs !== {1'b1, 3'd0, 24'(k), 16'(2 * k), 4'd0, 16'h0, 16'h0}) begin
        errs++; $display("FAIL tmo_nop_%0d got %h", k, tobs);
      end
    end
    t_if.pc = 16'h0028;
    tick();
    vecs++;
    if (tobs !== {1'b1, 3'd5, 24'd20, 16'h0028, 4'd0, 16'h0, 16'h0}) begin
      errs++; $display("FAIL tmo_record got %h", tobs);
    end
    t_if.pc = 16'h002A;
    tick();
    vecs++;
    if (t_if.done !== 1'b1 || t_if.out_valid !== 1'b0) begin
      errs++; $display("FAIL tmo_done got done %b valid %b exp 1 0", t_if.done, t_if.out_valid);
    end
    t_if.commit_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 16'(2 * i), 1'b1, 4'(i), 16'(16'h0100 + i), 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
      tick();
    end
    idle();
    u_if.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    vecs++;
    if (u_if.overflow !== 1'b1 || obs !== {1'b1, 3'd1, 24'd4, 16'h0008, 4'd4, 16'h0104, 16'h0}) begin
      errs++; $display("FAIL rstmid_pre got ovf %b head %h", u_if.overflow, obs);
    end
    u_if.out_ready = 1'b0;
    rst_n = 1'b0;
    tick();
    vecs++;
    if (u_if.out_valid !== 1'b0 || u_if.overflow !== 1'b0 || u_if.stall_req !== 1'b0) begin
      errs++; $display("FAIL rstmid_clear got valid %b ovf %b stall %b exp 0 0 0",
                       u_if.out_valid, u_if.overflow, u_if.stall_req);
    end
    rst_n = 1'b1;
    drive(1'b1, 16'h0030, 1'b1, 4'd2, 16'h0222, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    tick();
    vecs++;
    if (obs !== {1'b1, 3'd1, 24'd0, 16'h0030, 4'd2, 16'h0222, 16'h0}) begin
      errs++; $display("FAIL rstmid_first got %h", obs);
    end
    idle();
  endtask

  initial begin
    idle();
    u_if.out_ready = 1'b0;
    t_if.commit_valid = 1'b0; t_if.pc = 16'h0; t_if.reg_write = 1'b0;
    t_if.write_reg = 4'd0; t_if.write_data = 16'h0; t_if.mem_read = 1'b0;
    t_if.mem_write = 1'b0; t_if.mem_addr = 16'h0; t_if.mem_data = 16'h0;
    t_if.halt = 1'b0; t_if.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_classify();
    test_overflow();
    test_halt_full();
    test_timeout();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/commit_trace_unit.md
Name: commit_trace_unit

Overview:
Hardware producer of the per-instruction commit trace for the cpu.
Each cycle it samples the retire-stage signals: PC, register write, memory read/write and halt.
It classifies each retirement, tags it with a sequential instruction number (INUM), buffers it in a FIFO and streams the records out over a valid/ready interface.
The consumer is a trace sink: a bench monitor, a debug port or a comparator against the ISA simulator trace.

Parameters:
DEPTH, 8, FIFO entries (power of 2, >=2)
INUM_W, 24, width of instruction-number counter
MAX_CYCLES, 100000, cycle limit after which a timeout is forced

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
commit_valid  in  1  an instruction retires this cycle
pc  in  16  PC of retiring instruction
reg_write  in  1  retiring instruction writes register file
write_reg  in  4  destination register
write_data  in  16  data written to register
mem_read  in  1  retiring instruction read data memory
mem_write  in  1  retiring instruction wrote data memory
mem_addr  in  16  data memory address
mem_data  in  16  data stored (store) / loaded (load)
halt  in  1  retiring instruction is HLT
out_valid  out  1  record at FIFO head valid
out_ready  in  1  sink accepts record
out_kind  out  3  0 NOP/branch, 1 REG, 2 LD, 3 ST, 4 HALT, 5 TIMEOUT
out_inum  out  INUM_W  instruction number
out_pc  out  16  PC
out_reg  out  4  register (REG/LD, else 0)
out_value  out  16  write_data (REG/LD), mem_data (ST), else 0
out_addr  out  16  mem_addr (LD/ST), else 0
stall_req  out  1  FIFO has <=1 free entry; cpu should hold retirement
overflow  out  1  sticky: a record was dropped
done  out  1  halt/timeout record emitted and FIFO empty

Behaviour:
- Reset: FIFO empty. INUM=0, cycle counter=0, state RUN. Outputs out_valid/overflow/done=0, stall_req=0. Record fields are 0.
- Classification, in priority order:
  - reg_write&mem_read -> LD
  - reg_write -> REG
  - halt -> HALT
  - mem_write -> ST
  - otherwise NOP
- Record fields not used by the kind are forced to 0.
- Push: on a clk edge with commit_valid=1 in RUN, one record is built from same-cycle inputs and INUM is assigned. INUM increments by 1 per commit, whether the record is stored or dropped, and wraps at 2^INUM_W.
- Output: the record becomes visible on out_* with out_valid=1 at the edge after push (1-cycle latency when FIFO empty).
- Handshake: the head pops on an edge with out_valid&out_ready. out_* hold stable while out_valid=1 and out_ready=0.
- Full: a push is accepted when full only if a pop occurs the same edge. Otherwise the record is dropped and overflow is set; it clears only on reset.
- HALT is never dropped: if HALT arrives full with no pop, it is held in a 1-entry side register and pushed at the first free slot.
- Simultaneous push+pop when not full: occupancy is unchanged and ordering is preserved.
- stall_req is combinational from occupancy: asserted when free entries <=1.
- Cycle counter: increments every cycle in RUN. On reaching MAX_CYCLES, a TIMEOUT record is generated (pc=current pc, INUM=next, ignoring commit_valid that cycle), under the same never-drop rule as HALT.
- States:
  - RUN -> DRAIN when HALT or TIMEOUT is pushed (or parked).
  - DRAIN: commits are ignored, INUM is frozen, the FIFO drains.
  - DRAIN -> DONE when FIFO is empty and the side register is empty.
  - DONE: done=1, out_valid=0; held until reset.
- Reset mid-operation: on rst_n=0 at an edge, all state returns to reset values regardless of FIFO contents. Pending records are discarded.

Test Plan:
1. Reset; commit pc=0x0000 REG r3=0x1234, then pc=0x0002 ST addr=0x0010 data=0xBEEF, then pc=0x0004 HALT; out_ready=1 -> records (1,0,0x0000,3,0x1234,0), (3,1,0x0002,0,0xBEEF,0x0010), (4,2,0x0004,0,0,0). Each appears 1 cycle after its commit; done=1 the cycle after HALT pops.
2. reg_write=1, mem_read=1, write_reg=5, write_data=0x00AA, mem_addr=0x0020 -> kind LD, reg 5, value 0x00AA, addr 0x0020. With commit_valid=1 and no flags -> NOP with value/addr=0.
3. out_ready=0, DEPTH=8, 10 commits -> stall_req=1 once 7 are held. Records 9 and 10 are dropped and overflow=1. Then out_ready=1 -> INUM 0..7 emitted; the next commit receives INUM 10.
4. FIFO full, out_ready=0, HALT commit -> no drop and overflow unchanged. With out_ready=1 -> HALT emerges after the 8 buffered records; done=1 afterwards.
5. MAX_CYCLES=20, continuous NOP commits, out_ready=1 -> TIMEOUT record at cycle 20; further commits are ignored; done=1.
6. Reset asserted with 4 records buffered -> next cycle out_valid=0 and overflow=0. After release, the first commit gets INUM 0.
